// File: rtl/alu_decode_stage.sv
// RV32I decode stage: instruction + register reads -> ALU operation, operands, control bits; 1-cycle latency.
// Backpressure: holds outputs while out_ready is low; optional DECODE_SKID_EN adds a second entry and registered in_ready.
// flush drops held entries and any same-cycle input; reset_n asynchronously clears all outputs.
module alu_decode_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instr,
    input  logic [DATA_WIDTH-1:0]    pc,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_LENGTH-1:0] operation,
    output logic [DATA_WIDTH-1:0]    src_a,
    output logic [DATA_WIDTH-1:0]    src_b,
    output logic [DATA_WIDTH-1:0]    store_data,
    output logic [4:0]               rd,
    output logic                     reg_write,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic                     branch,
    output logic                     jump,
    output logic                     illegal
);

    typedef struct packed {
        logic [OPCODE_LENGTH-1:0] operation;
        logic [DATA_WIDTH-1:0]    src_a;
        logic [DATA_WIDTH-1:0]    src_b;
        logic [DATA_WIDTH-1:0]    store_data;
        logic [4:0]               rd;
        logic                     reg_write;
        logic                     mem_read;
        logic                     mem_write;
        logic                     branch;
        logic                     jump;
        logic                     illegal;
    } entry_t;

    localparam logic [3:0] OP_AND  = 4'b0000, OP_XOR  = 4'b0001, OP_ADD  = 4'b0010, OP_SLTI = 4'b0011;
    localparam logic [3:0] OP_BNE  = 4'b0100, OP_OR   = 4'b0101, OP_SLLI = 4'b0110, OP_SRAI = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000, OP_LUI  = 4'b1001, OP_SUB  = 4'b1010, OP_ADDI = 4'b1011;
    localparam logic [3:0] OP_SLT  = 4'b1100, OP_BLT  = 4'b1101, OP_SRLI = 4'b1110, OP_BGE  = 4'b1111;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_u, imm_j, shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    assign imm_s  = {{(DATA_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u  = DATA_WIDTH'($signed({instr[31:12], 12'b0}));
    assign imm_j  = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign shamt  = DATA_WIDTH'(instr[24:20]);

    entry_t     dec;
    logic [3:0] op;
    logic       legal;

    always_comb begin
        dec            = '0;
        dec.src_a      = rs1_data;
        dec.store_data = rs2_data;
        op             = OP_AND;
        legal          = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec.src_b     = rs2_data;
                dec.reg_write = 1'b1;
                if (funct7 == 7'b0000000) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  op = OP_ADD;
                        3'b111:  op = OP_AND;
                        3'b110:  op = OP_OR;
                        3'b100:  op = OP_XOR;
                        3'b010:  op = OP_SLT;
                        default: legal = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    legal = 1'b1;
                    op    = OP_SUB;
                end
            end
            7'b0010011: begin
                dec.src_b     = imm_i;
                dec.reg_write = 1'b1;
                legal         = 1'b1;
                case (funct3)
                    3'b000: op = OP_ADDI;
                    3'b010: op = OP_SLTI;
                    3'b111: op = OP_AND;
                    3'b110: op = OP_OR;
                    3'b100: op = OP_XOR;
                    3'b001: begin
                        dec.src_b = shamt;
                        op        = OP_SLLI;
                        legal     = (funct7 == 7'b0000000);
                    end
                    3'b101: begin
                        dec.src_b = shamt;
                        op        = (funct7 == 7'b0100000) ? OP_SRAI : OP_SRLI;
                        legal     = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                    default: legal = 1'b0;
                endcase
            end
            7'b0000011: begin
                legal = 1'b1; op = OP_ADD; dec.src_b = imm_i;
                dec.mem_read = 1'b1; dec.reg_write = 1'b1;
            end
            7'b0100011: begin
                legal = 1'b1; op = OP_ADD; dec.src_b = imm_s; dec.mem_write = 1'b1;
            end
            7'b1100011: begin
                dec.src_b  = rs2_data;
                dec.branch = 1'b1;
                legal      = 1'b1;
                case (funct3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    default: legal = 1'b0;
                endcase
            end
            7'b0110111: begin
                legal = 1'b1; op = OP_LUI; dec.src_a = '0; dec.src_b = imm_u; dec.reg_write = 1'b1;
            end
            7'b1101111: begin
                legal = 1'b1; op = OP_ADD; dec.src_a = pc; dec.src_b = imm_j;
                dec.jump = 1'b1; dec.reg_write = 1'b1;
            end
            7'b1100111: begin
                legal = 1'b1; op = OP_ADD; dec.src_b = imm_i;
                dec.jump = 1'b1; dec.reg_write = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // Unknown encodings still flow down the pipe so execute can raise the trap in order.
        if (!legal) begin
            dec            = '0;
            dec.src_a      = rs1_data;
            dec.store_data = rs2_data;
            dec.illegal    = 1'b1;
            op             = OP_AND;
        end
        dec.operation = OPCODE_LENGTH'(op);
        dec.rd        = dec.reg_write ? instr[11:7] : 5'd0;
    end

    entry_t out_q;

`ifdef DECODE_SKID_EN
    entry_t skid_q;
    logic   skid_vld;
    logic   accept;

    // in_ready comes straight from the skid flop, cutting the out_ready timing path.
    assign in_ready = !skid_vld;
    assign accept   = in_valid && !skid_vld && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            skid_vld  <= 1'b0;
            skid_q    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_vld  <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_vld) begin
                out_q     <= skid_q;
                out_valid <= 1'b1;
                skid_vld  <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) out_q <= dec;
            end
        end else if (accept) begin
            skid_q   <= dec;
            skid_vld <= 1'b1;
        end
    end
`else
    logic accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_ready) begin
            out_valid <= accept;
            if (accept) out_q <= dec;
        end
    end
`endif

    assign operation  = out_q.operation;
    assign src_a      = out_q.src_a;
    assign src_b      = out_q.src_b;
    assign store_data = out_q.store_data;
    assign rd         = out_q.rd;
    assign reg_write  = out_q.reg_write;
    assign mem_read   = out_q.mem_read;
    assign mem_write  = out_q.mem_write;
    assign branch     = out_q.branch;
    assign jump       = out_q.jump;
    assign illegal    = out_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: directed test-plan vectors, backpressure, flush, reset, random stream.
module tb_alu_decode_stage;

    typedef struct packed {
        logic [3:0]  operation;
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } exp_t;

`ifdef DECODE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] instr, pc, rs1_data, rs2_data, src_a, src_b, store_data;
    logic [3:0]  operation;
    logic [4:0]  rd;
    logic        reg_write, mem_read, mem_write, branch, jump, illegal;

    alu_decode_stage dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .operation(operation),
        .src_a(src_a), .src_b(src_b), .store_data(store_data), .rd(rd),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .jump(jump), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   or_mode = 2;          // 0 random out_ready, 1 held low, 2 held high
    exp_t expq[$];
    logic [3:0] code [string];

    function automatic exp_t got_now();
        exp_t g;
        g = '{operation, src_a, src_b, store_data, rd, reg_write, mem_read, mem_write, branch, jump, illegal};
        return g;
    endfunction

    // Operand values are don't-care for illegal entries.
    function automatic exp_t mask(exp_t e);
        exp_t m = e;
        if (m.illegal) begin m.src_a = '0; m.src_b = '0; end
        return m;
    endfunction

    function automatic exp_t mk(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] sd,
                                logic [4:0] r, logic [5:0] ctl);
        exp_t e;
        e = '{op, a, b, sd, r, ctl[5], ctl[4], ctl[3], ctl[2], ctl[1], ctl[0]};
        return e;
    endfunction

    // Reference: pick the mnemonic from the instruction fields, then look up its code.
    function automatic exp_t model(logic [31:0] w, logic [31:0] pcv, logic [31:0] a, logic [31:0] b);
        exp_t        e;
        string       m;
        logic [6:0]  opc = w[6:0];
        logic [2:0]  f3  = w[14:12];
        logic [6:0]  f7  = w[31:25];
        logic [31:0] ii  = 32'($signed(w) >>> 20);
        logic [31:0] si  = 32'($signed({w[31:25], w[11:7], 20'd0}) >>> 20);
        logic [31:0] ji  = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0, 11'd0}) >>> 11);
        logic [31:0] ui  = {w[31:12], 12'd0};
        logic [31:0] sh  = {27'd0, w[24:20]};
        e = '0; m = ""; e.src_a = a; e.store_data = b;
        case (opc)
            7'b0110011: begin
                e.src_b = b; e.reg_write = 1'b1;
                if (f7 == 7'd0) begin
                    case (f3)
                        3'd0: m = "ADD"; 3'd7: m = "AND"; 3'd6: m = "OR";
                        3'd4: m = "XOR"; 3'd2: m = "SLT"; default: m = "";
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) m = "SUB";
            end
            7'b0010011: begin
                e.reg_write = 1'b1;
                e.src_b = (f3 == 3'd1 || f3 == 3'd5) ? sh : ii;
                case (f3)
                    3'd0: m = "ADDI"; 3'd2: m = "SLTI"; 3'd7: m = "AND";
                    3'd6: m = "OR";   3'd4: m = "XOR";
                    3'd1: m = (f7 == 7'd0) ? "SLLI" : "";
                    3'd5: m = (f7 == 7'd0) ? "SRLI" : (f7 == 7'h20) ? "SRAI" : "";
                    default: m = "";
                endcase
            end
            7'b0000011: begin m = "ADD"; e.src_b = ii; e.mem_read = 1'b1; e.reg_write = 1'b1; end
            7'b0100011: begin m = "ADD"; e.src_b = si; e.mem_write = 1'b1; end
            7'b1100011: begin
                e.src_b = b; e.branch = 1'b1;
                case (f3)
                    3'd0: m = "BEQ"; 3'd1: m = "BNE"; 3'd4: m = "BLT"; 3'd5: m = "BGE";
                    default: m = "";
                endcase
            end
            7'b0110111: begin m = "LUI"; e.src_a = 0; e.src_b = ui; e.reg_write = 1'b1; end
            7'b1101111: begin m = "ADD"; e.src_a = pcv; e.src_b = ji; e.jump = 1'b1; e.reg_write = 1'b1; end
            7'b1100111: begin m = "ADD"; e.src_b = ii; e.jump = 1'b1; e.reg_write = 1'b1; end
            default: m = "";
        endcase
        if (m == "") begin
            e = '0; e.illegal = 1'b1; e.store_data = b;
        end else e.operation = code[m];
        e.rd = e.reg_write ? w[11:7] : 5'd0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        int          k = $urandom_range(0, 11);
        case (k)
            0, 9: begin
                w[6:0] = 7'b0110011;
                w[31:25] = ($urandom_range(0, 2) == 0) ? 7'b0100000 : 7'b0000000;
            end
            1, 10, 11: begin
                w[6:0] = 7'b0010011;
                if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
            end
            2: w[6:0] = 7'b0000011;
            3: w[6:0] = 7'b0100011;
            4: w[6:0] = 7'b1100011;
            5: w[6:0] = 7'b0110111;
            6: w[6:0] = 7'b1101111;
            7: w[6:0] = 7'b1100111;
            default: ;
        endcase
        return w;
    endfunction

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Entered and left at posedge+1; pushes the expectation when the handshake is seen.
    task automatic send(logic [31:0] w, logic [31:0] pcv, logic [31:0] a, logic [31:0] b,
                        bit directed, exp_t dexp);
        bit acc = 0;
        instr = w; pc = pcv; rs1_data = a; rs2_data = b; in_valid = 1'b1;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                expq.push_back(directed ? dexp : model(w, pcv, a, b));
                acc = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("send_accepted", 128'(acc), 128'(1));
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_empty();
        or_mode = 2;
        for (int t = 0; t < 60 && expq.size() != 0; t++) begin @(posedge clk); #1; end
        chk("drain_queue_empty", 128'(expq.size()), 128'(0));
    endtask

    initial begin
        forever begin
            @(posedge clk); #2;
            case (or_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    exp_t snap, cur, e;
    bit   prev_stall = 0;

    always @(negedge clk) begin
        if (!reset_n) prev_stall = 0;
        else begin
            cur = got_now();
            if (prev_stall) begin
                n_cmp++;
                if (!out_valid || cur !== snap) begin
                    n_bad++;
                    $display("FAIL stall_hold: got v=%0b %h expected v=1 %h", out_valid, cur, snap);
                end
            end
            prev_stall = out_valid && !out_ready && !flush;
            snap = cur;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output: got %h expected none", cur);
                end else begin
                    e = expq.pop_front();
                    if (mask(cur) !== mask(e)) begin
                        n_bad++;
                        $display("FAIL entry: got %h expected %h", mask(cur), mask(e));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        code["AND"] = 4'b0000; code["XOR"] = 4'b0001; code["ADD"]  = 4'b0010; code["SLTI"] = 4'b0011;
        code["BNE"] = 4'b0100; code["OR"]  = 4'b0101; code["SLLI"] = 4'b0110; code["SRAI"] = 4'b0111;
        code["BEQ"] = 4'b1000; code["LUI"] = 4'b1001; code["SUB"]  = 4'b1010; code["ADDI"] = 4'b1011;
        code["SLT"] = 4'b1100; code["BLT"] = 4'b1101; code["SRLI"] = 4'b1110; code["BGE"]  = 4'b1111;
        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        #2;
        chk("reset_outputs", 128'({out_valid, got_now()}), 128'(0));
        @(negedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", 128'(in_ready), 128'(1));

        // Test-plan vectors with hand-derived expectations (ctl = rw,mr,mw,br,jp,il).
        send(32'h002081B3, 32'h100, 32'd5, 32'd7, 1, mk(4'b0010, 32'd5, 32'd7, 32'd7, 5'd3, 6'b100000));
        send(32'h402081B3, 32'h104, 32'd9, 32'd4, 1, mk(4'b1010, 32'd9, 32'd4, 32'd4, 5'd3, 6'b100000));
        send(32'h40335293, 32'h108, 32'h80000000, 32'd1, 1,
             mk(4'b0111, 32'h80000000, 32'd3, 32'd1, 5'd5, 6'b100000));
        send(32'h123450B7, 32'h10C, 32'hDEADBEEF, 32'd2, 1,
             mk(4'b1001, 32'd0, 32'h12345000, 32'd2, 5'd1, 6'b100000));
        send(32'hFFFFFFFF, 32'h110, 32'd3, 32'd4, 1, mk(4'b0000, 32'd0, 32'd0, 32'd4, 5'd0, 6'b000001));
        idle(2);

        // Backpressure: four ADDIs against a stalled consumer.
        wait_empty();
        or_mode = 1;
        idle(1);
        send({12'd1, 5'd1, 3'b000, 5'd1, 7'b0010011}, 32'h200, $urandom, $urandom, 0, '0);
        chk("in_ready_one_held", 128'(in_ready), 128'(SKID));
`ifdef DECODE_SKID_EN
        send({12'd4, 5'd1, 3'b000, 5'd2, 7'b0010011}, 32'h204, $urandom, $urandom, 0, '0);
        chk("in_ready_two_held", 128'(in_ready), 128'(0));
        idle(1);
`else
        idle(2);
`endif
        or_mode = 2;
        for (int i = SKID ? 2 : 1; i < 4; i++)
            send({12'(i * 3 + 1), 5'd1, 3'b000, 5'(i + 1), 7'b0010011}, 32'h200 + 32'(4 * i),
                 $urandom, $urandom, 0, '0);

        // Flush while stalled with a concurrent input.
        wait_empty();
        or_mode = 1;
        idle(1);
        send(rand_instr(), $urandom, $urandom, $urandom, 0, '0);
`ifdef DECODE_SKID_EN
        send(rand_instr(), $urandom, $urandom, $urandom, 0, '0);
`endif
        flush = 1'b1; in_valid = 1'b1; instr = rand_instr();
        @(negedge clk); expq.delete();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        @(posedge clk); #1;
        or_mode = 2;
        idle(3);

        // Reset in the middle of a stall.
        wait_empty();
        or_mode = 1;
        idle(1);
        send(rand_instr(), $urandom, $urandom, $urandom, 0, '0);
        idle(1);
        #2 reset_n = 1'b0;
        #1 chk("reset_mid_stall", 128'({out_valid, got_now()}), 128'(0));
        expq.delete();
        @(negedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_mid_reset", 128'(in_ready), 128'(1));

        // Random stream against random backpressure.
        or_mode = 0;
        repeat (400) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            send(rand_instr(), $urandom, $urandom, $urandom, 0, '0);
        end
        wait_empty();
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
